// File: rtl/mux_scan_if.sv
// Bundles the control, mux-sample and result signals of the 16-channel scan sequencer.
// The slave modport is the sequencer side; the master modport is its controller/environment.
interface mux_scan_if #(
   parameter int INPUT_WIDTH = 1
) ();
   logic                      start;
   logic                      cont;
   logic                      abort;
   logic                      step_en;
   logic [INPUT_WIDTH-1:0]    mux_in;
   logic [3:0]                sel;
   logic                      busy;
   logic                      done;
   logic [16*INPUT_WIDTH-1:0] result;
   logic                      result_valid;

   modport master (
      output start, cont, abort, step_en, mux_in,
      input  sel, busy, done, result, result_valid
   );

   modport slave (
      input  start, cont, abort, step_en, mux_in,
      output sel, busy, done, result, result_valid
   );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a 16:1 mux select through all channels, captures each sample into a working
// buffer and publishes the whole buffer atomically when channel 15 has been captured.
module mux_scan_sequencer #(
   parameter int INPUT_WIDTH = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   mux_scan_if.slave  bus
);
   localparam int RW = 16 * INPUT_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      sel_q, sel_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            valid_q, valid_d;
   logic [RW-1:0]   work_q, work_d;
   logic [RW-1:0]   result_q, result_d;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      sel_d    = sel_q;
      work_d   = work_q;
      result_d = result_q;
      valid_d  = valid_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = SCAN;
               sel_d   = '0;
            end
         end
         SCAN: begin
            if (bus.abort) begin
               state_d = IDLE;
               sel_d   = '0;
            end else if (bus.step_en) begin
               // NOTE: blocking writes here so the publish below sees slot 15 already filled.
               work_d[int'(sel_q)*INPUT_WIDTH +: INPUT_WIDTH] = bus.mux_in;
               if (sel_q == 4'd15) begin
                  state_d  = DONE;
                  sel_d    = '0;
                  result_d = work_d;
                  valid_d  = 1'b1;
               end else begin
                  sel_d = sel_q + 4'd1;
               end
            end
         end
         DONE: begin
            sel_d   = '0;
            state_d = (bus.cont && !bus.abort) ? SCAN : IDLE;
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
         end
      endcase

      busy_d = (state_d == SCAN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the working buffer is cleared on reset too, so no stale partial scan survives.
         state_q  <= IDLE;
         sel_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         work_q   <= '0;
         result_q <= '0;
      end else begin
         // NOTE: non-blocking assignments for all registered state.
         state_q  <= state_d;
         sel_q    <= sel_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
         work_q   <= work_d;
         result_q <= result_d;
      end
   end

   assign bus.sel          = sel_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.result       = result_q;
   assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Drives a 1-bit and a 4-bit sequencer from shared controls; each mux is a per-channel
// data table indexed by the DUT's own sel, and expected results are packed from that table.
module tb_mux_scan_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   logic start, cont, abort, step_en;

   logic       data1 [16];
   logic [3:0] data4 [16];

   int total = 0;
   int bad   = 0;

   mux_scan_if #(.INPUT_WIDTH(1)) bus1 ();
   mux_scan_if #(.INPUT_WIDTH(4)) bus4 ();

   assign bus1.start   = start;
   assign bus1.cont    = cont;
   assign bus1.abort   = abort;
   assign bus1.step_en = step_en;
   assign bus1.mux_in  = data1[bus1.sel];
   assign bus4.start   = start;
   assign bus4.cont    = cont;
   assign bus4.abort   = abort;
   assign bus4.step_en = step_en;
   assign bus4.mux_in  = data4[bus4.sel];

   mux_scan_sequencer #(.INPUT_WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   mux_scan_sequencer #(.INPUT_WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pack1();
      logic [15:0] r;
      for (int k = 0; k < 16; k++) r[k] = data1[k];
      return r;
   endfunction

   function automatic logic [63:0] pack4();
      logic [63:0] r;
      for (int k = 0; k < 16; k++) r[k*4 +: 4] = data4[k];
      return r;
   endfunction

   task automatic fill_random();
      for (int k = 0; k < 16; k++) begin
         data1[k] = 1'($urandom);
         data4[k] = 4'($urandom);
      end
   endtask

   // Accept a start from IDLE and confirm the scan begins at channel 0.
   task automatic start_scan(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (bus1.busy !== 1'b1 || bus1.sel !== 4'd0 || bus4.busy !== 1'b1 || bus4.sel !== 4'd0) begin
         $display("FAIL %s start: busy=%b sel=%0d expected busy=1 sel=0", tag, bus1.busy, bus1.sel);
         bad++;
      end
   endtask

   // From SCAN at sel=0, run a scan whose step_en is low on the cycles set in stalls,
   // and check the DONE cycle that follows.
   task automatic scan_body(input logic [15:0] stalls, input logic hold_start, input string tag);
      int steps = 0;
      int cyc   = 0;
      int exp_cyc = 16 + $countones(stalls);
      logic [15:0] r1_before = bus1.result;
      logic [63:0] r4_before = bus4.result;
      logic [15:0] e1 = pack1();
      logic [63:0] e4 = pack4();
      while (steps < 16 && cyc < 100) begin
         total++;
         if (bus1.busy !== 1'b1 || bus1.done !== 1'b0 || bus1.sel !== steps[3:0] || bus4.sel !== steps[3:0]) begin
            $display("FAIL %s scan cyc %0d: busy=%b done=%b sel=%0d expected busy=1 done=0 sel=%0d",
                     tag, cyc, bus1.busy, bus1.done, bus1.sel, steps);
            bad++;
         end
         total++;
         if (bus1.result !== r1_before || bus4.result !== r4_before) begin
            $display("FAIL %s partial cyc %0d: result=%h expected unchanged %h", tag, cyc, bus1.result, r1_before);
            bad++;
         end
         step_en = (cyc < 16) ? !stalls[cyc] : 1'b1;
         start   = hold_start;
         tick();
         if (step_en) steps++;
         cyc++;
      end
      step_en = 1'b1;
      total++;
      if (cyc !== exp_cyc) begin
         $display("FAIL %s latency: scan cycles=%0d expected %0d", tag, cyc, exp_cyc);
         bad++;
      end
      total++;
      if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || bus4.done !== 1'b1 || bus1.sel !== 4'd0) begin
         $display("FAIL %s done: done=%b busy=%b sel=%0d expected done=1 busy=0 sel=0",
                  tag, bus1.done, bus1.busy, bus1.sel);
         bad++;
      end
      total++;
      if (bus1.result !== e1 || bus1.result_valid !== 1'b1) begin
         $display("FAIL %s result1: got %h valid=%b expected %h valid=1", tag, bus1.result, bus1.result_valid, e1);
         bad++;
      end
      total++;
      if (bus4.result !== e4 || bus4.result_valid !== 1'b1) begin
         $display("FAIL %s result4: got %h valid=%b expected %h valid=1", tag, bus4.result, bus4.result_valid, e4);
         bad++;
      end
   endtask

   // Leave DONE with the given cont/abort and expect IDLE.
   task automatic exit_to_idle(input string tag);
      tick();
      start = 1'b0;
      total++;
      if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus4.busy !== 1'b0 || bus1.sel !== 4'd0) begin
         $display("FAIL %s idle: busy=%b done=%b sel=%0d expected busy=0 done=0 sel=0",
                  tag, bus1.busy, bus1.done, bus1.sel);
         bad++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; cont = 1'b1; abort = 1'b0; step_en = 1'b1;
      for (int k = 0; k < 16; k++) begin data1[k] = 1'b1; data4[k] = 4'hF; end
      tick(); tick();
      total++;
      if (bus1.sel !== 4'd0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.result !== 16'h0 ||
          bus1.result_valid !== 1'b0 || bus4.result !== 64'h0 || bus4.busy !== 1'b0) begin
         $display("FAIL reset: sel=%0d busy=%b done=%b result=%h valid=%b expected all zero",
                  bus1.sel, bus1.busy, bus1.done, bus1.result, bus1.result_valid);
         bad++;
      end
      start = 1'b0; cont = 1'b0;
      rst_n = 1'b1;
      tick();
      total++;
      if (bus1.busy !== 1'b0 || bus1.result_valid !== 1'b0) begin
         $display("FAIL reset idle: busy=%b valid=%b expected 0 0", bus1.busy, bus1.result_valid);
         bad++;
      end
   endtask

   task automatic test_single_scan();
      for (int k = 0; k < 16; k++) begin
         data1[k] = k[0];
         data4[k] = k[3:0];
      end
      start_scan("single");
      scan_body(16'h0000, 1'b0, "single");
      total++;
      if (bus1.result !== 16'hAAAA || bus4.result !== 64'hFEDCBA9876543210) begin
         $display("FAIL single const: result1=%h result4=%h expected aaaa fedcba9876543210",
                  bus1.result, bus4.result);
         bad++;
      end
      exit_to_idle("single");
   endtask

   task automatic test_stall();
      for (int k = 0; k < 16; k++) data1[k] = k[0];
      start_scan("stall");
      scan_body(16'b0000_0010_0000_1000, 1'b0, "stall");
      total++;
      if (bus1.result !== 16'hAAAA) begin
         $display("FAIL stall const: result=%h expected aaaa", bus1.result);
         bad++;
      end
      exit_to_idle("stall");
   endtask

   task automatic test_abort();
      logic [15:0] v = 16'h1234;
      logic [63:0] saved4;
      for (int k = 0; k < 16; k++) data1[k] = v[k];
      fill_random_4();
      start_scan("abort pre");
      scan_body(16'h0000, 1'b0, "abort pre");
      exit_to_idle("abort pre");
      saved4 = pack4();
      for (int k = 0; k < 16; k++) data1[k] = ~v[k];
      fill_random_4();
      start_scan("abort");
      for (int i = 0; i < 7; i++) tick();
      total++;
      if (bus1.sel !== 4'd7) begin
         $display("FAIL abort sel: sel=%0d expected 7", bus1.sel);
         bad++;
      end
      abort = 1'b1;
      tick();
      total++;
      if (bus1.busy !== 1'b0 || bus1.sel !== 4'd0 || bus1.done !== 1'b0 || bus1.result !== 16'h1234 ||
          bus1.result_valid !== 1'b1 || bus4.result !== saved4) begin
         $display("FAIL abort: busy=%b sel=%0d done=%b result=%h valid=%b expected 0 0 0 1234 1",
                  bus1.busy, bus1.sel, bus1.done, bus1.result, bus1.result_valid);
         bad++;
      end
      tick();
      total++;
      if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
         $display("FAIL abort after: done=%b busy=%b expected 0 0", bus1.done, bus1.busy);
         bad++;
      end
      // abort is ignored in IDLE: start still launches a scan
      start = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      total++;
      if (bus1.busy !== 1'b1 || bus1.sel !== 4'd0) begin
         $display("FAIL abort idle start: busy=%b sel=%0d expected 1 0", bus1.busy, bus1.sel);
         bad++;
      end
      scan_body(16'h0000, 1'b0, "abort post");
      exit_to_idle("abort post");
   endtask

   task automatic fill_random_4();
      for (int k = 0; k < 16; k++) data4[k] = 4'($urandom);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 16; k++) data1[k] = k[3];
      fill_random_4();
      cont = 1'b1;
      start_scan("cont 1");
      scan_body(16'h0000, 1'b0, "cont 1");
      tick();
      total++;
      if (bus1.busy !== 1'b1 || bus1.sel !== 4'd0 || bus1.done !== 1'b0) begin
         $display("FAIL cont rescan: busy=%b sel=%0d done=%b expected 1 0 0", bus1.busy, bus1.sel, bus1.done);
         bad++;
      end
      cont = 1'b0;
      fill_random_4();
      scan_body(16'h0000, 1'b0, "cont 2");
      total++;
      if (bus1.result !== 16'hFF00) begin
         $display("FAIL cont const: result=%h expected ff00", bus1.result);
         bad++;
      end
      exit_to_idle("cont 2");
      tick();
      total++;
      if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
         $display("FAIL cont stay idle: busy=%b done=%b expected 0 0", bus1.busy, bus1.done);
         bad++;
      end
      // abort in DONE with cont=1 forces IDLE
      cont = 1'b1;
      start_scan("cont abort");
      scan_body(16'h0000, 1'b0, "cont abort");
      abort = 1'b1;
      exit_to_idle("cont abort");
      abort = 1'b0; cont = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 16; k++) begin data1[k] = 1'b1; data4[k] = 4'hF; end
      start_scan("rst pre");
      scan_body(16'h0000, 1'b0, "rst pre");
      total++;
      if (bus1.result !== 16'hFFFF) begin
         $display("FAIL rst pre const: result=%h expected ffff", bus1.result);
         bad++;
      end
      exit_to_idle("rst pre");
      start_scan("rst mid");
      for (int i = 0; i < 10; i++) tick();
      total++;
      if (bus1.sel !== 4'd10) begin
         $display("FAIL rst mid sel: sel=%0d expected 10", bus1.sel);
         bad++;
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total++;
      if (bus1.sel !== 4'd0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.result !== 16'h0 ||
          bus1.result_valid !== 1'b0 || bus4.result !== 64'h0 || bus4.result_valid !== 1'b0) begin
         $display("FAIL rst mid: sel=%0d busy=%b done=%b result=%h valid=%b expected all zero",
                  bus1.sel, bus1.busy, bus1.done, bus1.result, bus1.result_valid);
         bad++;
      end
      fill_random();
      start_scan("rst fresh");
      scan_body(16'h0000, 1'b0, "rst fresh");
      exit_to_idle("rst fresh");
   endtask

   task automatic test_random();
      for (int n = 0; n < 10; n++) begin
         int abort_at;
         logic [15:0] stalls;
         logic [15:0] r1;
         logic [63:0] r4;
         logic hold;
         fill_random();
         stalls   = 16'($urandom) & 16'($urandom);
         hold     = 1'($urandom);
         abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
         if (abort_at >= 0) begin
            r1 = bus1.result;
            r4 = bus4.result;
            start_scan("rand abort");
            for (int i = 0; i < abort_at; i++) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            total++;
            if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.sel !== 4'd0 ||
                bus1.result !== r1 || bus4.result !== r4) begin
               $display("FAIL rand abort %0d at %0d: busy=%b done=%b result=%h expected 0 0 %h",
                        n, abort_at, bus1.busy, bus1.done, bus1.result, r1);
               bad++;
            end
         end else begin
            start_scan("rand");
            scan_body(stalls, hold, "rand");
            exit_to_idle("rand");
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0; step_en = 1'b1;
      test_reset();
      test_single_scan();
      test_stall();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
